// File: rtl/aoc4_pkg.sv
// Shared types for the grid row reader.
package aoc4_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } rd_state_e;
endpackage

// File: rtl/aoc4.svh
// Shared widths for the grid row datapath.
`ifndef AOC4_SVH
`define AOC4_SVH
`define GRID_VEC_ALIGN_N 16
`endif

// File: rtl/row_skid_fifo.sv
// Two-entry FIFO; the head entry is a register so outputs come straight from flops.
module row_skid_fifo #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         valid_o,
  output logic [1:0]   count_o
);
  logic [W-1:0] head_q, tail_q;
  logic [1:0]   cnt_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      case ({push_i, pop_i})
        2'b10: begin
          if (cnt_q == 2'd0) head_q <= din_i;
          else               tail_q <= din_i;
          cnt_q <= cnt_q + 2'd1;
        end
        2'b01: begin
          head_q <= tail_q;
          cnt_q  <= cnt_q - 2'd1;
        end
        2'b11: begin
          // Occupancy unchanged; the new row slides in behind whatever remains.
          if (cnt_q == 2'd1) head_q <= din_i;
          else begin
            head_q <= tail_q;
            tail_q <= din_i;
          end
        end
        default: ;
      endcase
    end
  end

  assign dout_o  = head_q;
  assign valid_o = (cnt_q != 2'd0);
  assign count_o = cnt_q;
endmodule

// File: rtl/grid_row_reader.sv
// Streams rows 0..count-1 out of a latency-1 RAM into a ready/valid port.
`include "aoc4.svh"
module grid_row_reader
  import aoc4_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 16
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic [ADDR_WIDTH:0]          row_count,
  output logic                         busy,
  output logic                         done,
  output logic [ADDR_WIDTH-1:0]        ram_addr,
  output logic                         ram_bank_sel,
  output logic                         ram_write_en,
  input  logic [`GRID_VEC_ALIGN_N-1:0] ram_read_data,
  output logic [`GRID_VEC_ALIGN_N-1:0] row_data,
  output logic                         row_valid,
  input  logic                         row_ready,
  output logic [ADDR_WIDTH-1:0]        row_index,
  output logic                         row_last
);
  localparam int CW = ADDR_WIDTH + 1;
  localparam int DW = `GRID_VEC_ALIGN_N;
  localparam int PW = DW + ADDR_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  rd_state_e             state_q;
  logic [CW-1:0]         count_q, addr_q, cnt_eff;
  logic                  inflight_q;
  logic [ADDR_WIDTH-1:0] rd_idx_q;
  logic [1:0]            fifo_cnt;
  logic [2:0]            load;
  logic                  pop, issue, push, head_last;
  logic [PW-1:0]         fifo_din, fifo_dout;

  assign cnt_eff = (row_count > DEPTH_C) ? DEPTH_C : row_count;
  assign pop     = row_valid & row_ready;
  // Rows already committed to the FIFO slots: what survives this pop plus the read landing now.
  assign load    = {1'b0, fifo_cnt} - {2'b00, pop} + {2'b00, inflight_q};
  assign issue   = (state_q == STREAM) && (addr_q < count_q) && (load < 3'd2);

  assign ram_bank_sel = issue;
  assign ram_addr     = addr_q[ADDR_WIDTH-1:0];
  assign ram_write_en = 1'b0;
  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DONE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      count_q    <= '0;
      addr_q     <= '0;
      inflight_q <= 1'b0;
      rd_idx_q   <= '0;
    end else begin
      inflight_q <= issue;
      if (issue) rd_idx_q <= ram_addr;
      case (state_q)
        IDLE: if (start) begin
          count_q <= cnt_eff;
          addr_q  <= '0;
          state_q <= (cnt_eff == '0) ? DONE : STREAM;
        end
        STREAM: begin
          if (issue) addr_q <= addr_q + CW'(1);
          if (pop && head_last) state_q <= DONE;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign push     = inflight_q;
  assign fifo_din = {ram_read_data, rd_idx_q, ({1'b0, rd_idx_q} == count_q - CW'(1))};

  row_skid_fifo #(.W(PW)) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push_i  (push),
    .din_i   (fifo_din),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .valid_o (row_valid),
    .count_o (fifo_cnt)
  );

  assign {row_data, row_index, head_last} = fifo_dout;
  assign row_last = head_last & row_valid;
endmodule

// File: tb/tb_grid_row_reader.sv
// Table-driven passes checked against a queue model of the expected row stream.
`ifndef GRID_VEC_ALIGN_N
`define GRID_VEC_ALIGN_N 16
`endif
module tb_grid_row_reader;
  localparam int AW = 4, DEPTH = 16, DW = `GRID_VEC_ALIGN_N;

  logic          clock = 1'b0, reset_n, start, row_ready;
  logic [AW:0]   row_count;
  logic          busy, done, ram_bank_sel, ram_write_en, row_valid, row_last;
  logic [AW-1:0] ram_addr, row_index;
  logic [DW-1:0] ram_read_data, row_data;
  logic [DW-1:0] mem [DEPTH];

  int cycle = 0;
  int n_vec = 0, n_err = 0;

  grid_row_reader #(.ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .row_count(row_count),
    .busy(busy), .done(done), .ram_addr(ram_addr), .ram_bank_sel(ram_bank_sel),
    .ram_write_en(ram_write_en), .ram_read_data(ram_read_data), .row_data(row_data),
    .row_valid(row_valid), .row_ready(row_ready), .row_index(row_index), .row_last(row_last)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cycle <= cycle + 1;
  always @(posedge clock) if (ram_bank_sel) ram_read_data <= mem[ram_addr];

  typedef struct { int n; bit rnd; bit rmem; int poke; int exp_rows; int exp_done; } vec_t;
  typedef struct { int d; int idx; bit last; } row_t;
  vec_t tbl[8];

  function automatic void chk(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cycle);
    end
  endfunction

  task automatic run_pass(input vec_t v);
    row_t exp_q[$];
    row_t e;
    int neff, c0, issued, rx, first_v, done_cyc, k;
    bit fin, hs, prev_stall;
    logic [DW-1:0] pd;
    logic [AW-1:0] pi;
    logic pl;
    neff = (v.n > DEPTH) ? DEPTH : v.n;
    for (int i = 0; i < DEPTH; i++) mem[i] = v.rmem ? DW'($urandom) : DW'(i * 3);
    for (int i = 0; i < neff; i++) exp_q.push_back('{int'(mem[i]), i, i == neff - 1});
    issued = 0; rx = 0; first_v = -1; done_cyc = -1; fin = 0; prev_stall = 0;
    pd = '0; pi = '0; pl = 1'b0;

    @(posedge clock); #1;
    start = 1'b1; row_count = v.n[AW:0]; row_ready = v.rnd ? 1'($urandom) : 1'b1; c0 = cycle;
    @(negedge clock);
    chk("busy_at_start", busy, 0);
    for (k = 1; k < 300 && !fin; k++) begin
      @(posedge clock); #1;
      start = (k == v.poke);
      if (k == v.poke) row_count = 5'd2;
      row_ready = v.rnd ? 1'($urandom) : 1'b1;
      @(negedge clock);
      chk("cycle_align", cycle - c0, k);
      chk("write_en", ram_write_en, 0);
      hs = row_valid && row_ready;
      if (row_valid && first_v < 0) first_v = k;
      if (prev_stall) begin
        chk("stall_valid", row_valid, 1);
        chk("stall_data", int'(row_data), int'(pd));
        chk("stall_index", row_index, pi);
        chk("stall_last", row_last, pl);
      end
      if (ram_bank_sel) begin
        chk("rd_addr_order", ram_addr, issued);
        chk("rd_in_range", int'(issued < neff), 1);
        chk("rd_slot_free", int'(issued - rx - int'(hs) < 2), 1);
        issued++;
      end
      if (hs) begin
        if (exp_q.size() == 0) chk("extra_row", row_index, -1);
        else begin
          e = exp_q.pop_front();
          chk("row_data", int'(row_data), e.d);
          chk("row_index", row_index, e.idx);
          chk("row_last", row_last, e.last);
        end
        rx++;
      end
      prev_stall = row_valid && !row_ready;
      pd = row_data; pi = row_index; pl = row_last;
      if (done) begin done_cyc = k; fin = 1; end
    end
    if (!fin) chk("done_timeout", 0, 1);
    @(posedge clock); #1 start = 1'b0;
    @(negedge clock);
    chk("idle_after_done", busy, 0);
    chk("done_pulse_width", done, 0);
    chk("rows_delivered", rx, v.exp_rows);
    chk("reads_issued", issued, neff);
    if (v.exp_done >= 0) chk("done_cycle", done_cyc, v.exp_done);
    if (v.exp_rows > 0) chk("first_valid_cycle", first_v, 3);
    else chk("no_row_valid", first_v, -1);
  endtask

  task automatic reset_mid_pass();
    int rx;
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i * 3 + 1);
    @(posedge clock); #1 start = 1'b1; row_count = 5'd8; row_ready = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    rx = 0;
    for (int k = 0; k < 50 && rx < 2; k++) begin
      @(negedge clock);
      if (row_valid && row_ready) rx++;
    end
    chk("rst_rows_before", rx, 2);
    @(posedge clock); #2 reset_n = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_row_valid", row_valid, 0);
    chk("rst_row_last", row_last, 0);
    chk("rst_bank_sel", ram_bank_sel, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_row_index", row_index, 0);
    @(negedge clock); reset_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      chk("post_rst_valid", row_valid, 0);
      chk("post_rst_busy", busy, 0);
    end
  endtask

  initial begin
    //          n  rnd rmem poke rows done
    tbl[0] = '{ 4, 0, 0, -1,  4,  7};
    tbl[1] = '{ 0, 0, 0, -1,  0,  1};
    tbl[2] = '{20, 0, 1, -1, 16, 19};
    tbl[3] = '{ 1, 0, 1, -1,  1,  4};
    tbl[4] = '{ 5, 1, 1, -1,  5, -1};
    tbl[5] = '{16, 1, 1, -1, 16, -1};
    tbl[6] = '{ 6, 0, 1,  2,  6,  9};
    tbl[7] = '{ 7, 1, 1,  4,  7, -1};

    reset_n = 1'b0; start = 1'b0; row_count = '0; row_ready = 1'b0;
    #3;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_valid", row_valid, 0);
    chk("reset_bank_sel", ram_bank_sel, 0);
    chk("reset_addr", ram_addr, 0);
    @(negedge clock); reset_n = 1'b1;

    for (int t = 0; t < 8; t++) run_pass(tbl[t]);
    for (int r = 0; r < 3; r++) run_pass('{5, 1, 1, -1, 5, -1});
    reset_mid_pass();
    run_pass(tbl[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
